// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//
// Iterative radix-2 restoring divider for the RV32M div/divu/rem/remu group.
// It sits in the EX stage beside the ALU and takes the same operands. A normal
// operation produces one quotient bit per cycle and finishes DATA_WIDTH+1
// cycles after it is accepted. Divide-by-zero and signed overflow skip the
// iteration loop and finish two cycles after accept. busy_o stays high for the
// whole operation so the hazard unit can stall the pipeline.
//
// Ports
//   clk      in   1           rising-edge clock
//   rst_n    in   1           synchronous active-low reset
//   start_i  in   1           request pulse; op_i/a_i/b_i sampled on accept
//   op_i     in   2           00 div, 01 divu, 10 rem, 11 remu
//   a_i      in   DATA_WIDTH  dividend
//   b_i      in   DATA_WIDTH  divisor
//   flush_i  in   1           abort the in-flight operation
//   busy_o   out  1           operation in progress; start_i ignored while high
//   done_o   out  1           one-cycle pulse, res_o valid
//   res_o    out  DATA_WIDTH  quotient or remainder, held until next done_o
// -----------------------------------------------------------------------------
module div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] res_o
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic                  is_rem;
  logic                  neg_res;
  logic                  special;
  logic                  fin_wait;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic [DATA_WIDTH-1:0] part_rem;

  // Accept-time decode of the incoming operands.
  logic                  signed_op;
  logic                  a_neg;
  logic                  b_neg;
  logic [DATA_WIDTH-1:0] a_mag;
  logic [DATA_WIDTH-1:0] b_mag;
  logic                  div_zero;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] special_res;
  logic                  neg_flag;

  // Per-iteration datapath.
  logic [DATA_WIDTH:0]   rem_shift;
  logic [DATA_WIDTH:0]   trial;
  logic                  borrow;

  // Final result selection with sign correction.
  logic [DATA_WIDTH-1:0] quot_fix;
  logic [DATA_WIDTH-1:0] rem_fix;
  logic [DATA_WIDTH-1:0] fin_res;

  // Operand decode: magnitudes are taken only for signed ops. The magnitude of
  // the most negative value is the same bit pattern, which is correct when it
  // is read as unsigned.
  always_comb begin
    signed_op = ~op_i[0];
    a_neg     = signed_op & a_i[DATA_WIDTH-1];
    b_neg     = signed_op & b_i[DATA_WIDTH-1];
    a_mag     = a_neg ? (~a_i + ONE) : a_i;
    b_mag     = b_neg ? (~b_i + ONE) : b_i;
    div_zero  = (b_i == '0);
    overflow  = signed_op & (a_i == MOST_NEG) & (b_i == ALL_ONES);

    // Remainder takes the sign of the dividend; quotient is negative when the
    // operand signs differ.
    neg_flag  = op_i[1] ? a_neg : (a_neg ^ b_neg);

    special_res = '0;
    if (div_zero) begin
      special_res = op_i[1] ? a_i : ALL_ONES;
    end else if (overflow) begin
      special_res = op_i[1] ? '0 : a_i;
    end
  end

  // Restoring step. The shifted remainder carries one extra bit, so the trial
  // subtract cannot overflow and its top bit is the borrow. After a restore
  // the extra bit is known to be zero, since the value is below the divisor.
  always_comb begin
    rem_shift = {part_rem, dividend[DATA_WIDTH-1]};
    trial     = rem_shift - {1'b0, divisor};
    borrow    = trial[DATA_WIDTH];
  end

  // The dividend register doubles as the quotient register: dividend bits
  // shift out the top while quotient bits shift in at the bottom. For special
  // cases it already holds the final, uncorrected result.
  always_comb begin
    quot_fix = neg_res ? (~dividend + ONE) : dividend;
    rem_fix  = neg_res ? (~part_rem + ONE) : part_rem;
    if (special) begin
      fin_res = dividend;
    end else if (is_rem) begin
      fin_res = rem_fix;
    end else begin
      fin_res = quot_fix;
    end
  end

  // Control FSM and datapath registers. A flush outside IDLE drops the
  // operation without touching res_o. Special cases spend two cycles in FIN
  // (fin_wait) so that their latency is a fixed two cycles after accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      is_rem   <= 1'b0;
      neg_res  <= 1'b0;
      special  <= 1'b0;
      fin_wait <= 1'b0;
      dividend <= '0;
      divisor  <= '0;
      part_rem <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      res_o    <= '0;
    end else begin
      done_o <= 1'b0;
      if ((state != IDLE) && flush_i) begin
        state    <= IDLE;
        busy_o   <= 1'b0;
        fin_wait <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i && !flush_i) begin
              busy_o   <= 1'b1;
              is_rem   <= op_i[1];
              neg_res  <= neg_flag;
              divisor  <= b_mag;
              part_rem <= '0;
              cnt      <= CNT_LAST;
              if (div_zero || overflow) begin
                special  <= 1'b1;
                fin_wait <= 1'b1;
                dividend <= special_res;
                state    <= FIN;
              end else begin
                special  <= 1'b0;
                fin_wait <= 1'b0;
                dividend <= a_mag;
                state    <= CALC;
              end
            end
          end

          CALC: begin
            part_rem <= borrow ? rem_shift[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
            dividend <= {dividend[DATA_WIDTH-2:0], ~borrow};
            cnt      <= cnt - CNT_ONE;
            if (cnt == '0) begin
              state <= FIN;
            end
          end

          FIN: begin
            if (fin_wait) begin
              fin_wait <= 1'b0;
            end else begin
              res_o  <= fin_res;
              done_o <= 1'b1;
              busy_o <= 1'b0;
              state  <= IDLE;
            end
          end

          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative multi-cycle divider for the RV32M div/divu/rem/remu group.
- Sits in the EX stage beside alu and is fed by the same operand muxes as alu a_i/b_i.
- Its registered result is selected onto the EX result path in place of the combinational ALU divide/remainder outputs.
- Holds busy_o high while working so the hazard unit can stall the pipeline.

Parameters:
- DATA_WIDTH, 32, operand and result width; iteration counter width is clog2(DATA_WIDTH).

Ports:
- clk, input, 1, rising-edge clock
- rst_n, input, 1, synchronous active-low reset
- start_i, input, 1, request pulse; operands and op sampled at the accepting edge
- op_i, input, 2, 00 div, 01 divu, 10 rem, 11 remu
- a_i, input, DATA_WIDTH, dividend
- b_i, input, DATA_WIDTH, divisor
- flush_i, input, 1, abort in-flight operation (branch/trap flush)
- busy_o, output, 1, operation in progress; start_i ignored while high
- done_o, output, 1, one-cycle pulse: res_o valid
- res_o, output, DATA_WIDTH, quotient or remainder (registered)

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge): state IDLE, busy_o=0, done_o=0, res_o=0, counter=0. Reset mid-operation discards the operation; no done_o is produced.
- States and transitions:
  - IDLE -> CALC on start_i.
  - IDLE -> FIN on start_i with a special case.
  - CALC -> FIN after DATA_WIDTH iterations.
  - FIN -> IDLE unconditionally.
- Accept: in IDLE with start_i=1 and flush_i=0. Latch op, sign flags, |a| and |b|; |x| is used only for signed ops (div, rem), raw values otherwise. Clear the partial remainder and load counter=DATA_WIDTH-1.
- busy_o=1 from the accepting edge until the edge on which done_o rises. Operands may change after the accepting edge.
- CALC: radix-2 restoring, one quotient bit per cycle, MSB first.
  - Shift the partial remainder left, bringing in the next dividend bit, then trial-subtract the divisor.
  - On no borrow, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
  - Exactly DATA_WIDTH cycles; the counter wraps from 0 to exit to FIN.
  - The partial remainder is DATA_WIDTH+1 bits wide to avoid overflow on the trial subtract.
- FIN, sign correction:
  - div: negate the quotient if sign(a) != sign(b).
  - rem: negate the remainder if sign(a)=1.
  - divu/remu: no correction.
  - Register res_o, pulse done_o=1 for exactly one cycle, clear busy_o, return to IDLE.
- Latency, normal path: start_i sampled at edge k -> done_o high and res_o valid after edge k+DATA_WIDTH+1 (k+33 at default).
- Special cases, detected at accept, skip CALC; result registered at edge k+2 (IDLE -> FIN -> done):
  - b=0: div/divu -> all ones; rem/remu -> a.
  - Signed overflow (div/rem, a=most-negative, b=-1): div -> a (0x80000000); rem -> 0.
- res_o holds its last value until the next done_o; done_o is never high on two consecutive cycles.
- flush_i=1 at any edge while not in IDLE: return to IDLE, busy_o=0, no done_o, res_o unchanged.
- flush_i and start_i both high in IDLE: flush wins, nothing accepted.
- start_i while busy_o=1: ignored, with no queueing.
- Back-to-back: a new start_i may be accepted on the edge after done_o rises (unit back in IDLE).
- No X on outputs after reset; op_i, a_i and b_i are don't-care when not accepted.

Test Plan:
- divu 100/7: start op=01, a=100, b=7 -> done_o exactly 33 edges after accept, res_o=14; remu same operands -> 2.
- Signed ops:
  - div -7/2 -> 0xFFFFFFFD (-3).
  - rem -7/2 -> 0xFFFFFFFF (-1).
  - rem 7/-2 -> 1.
  - divu 0xFFFFFFFF/1 -> 0xFFFFFFFF with no sign correction.
- Divide by zero: div 5/0 -> 0xFFFFFFFF; rem 5/0 -> 5; each with done_o two edges after accept and no CALC cycles.
- Overflow: div 0x80000000/0xFFFFFFFF -> 0x80000000; rem -> 0; latency two edges.
- Flush and reset:
  - Accept divu 1000/3, assert flush_i at cycle 10 -> busy_o=0, no done_o, res_o keeps its prior value.
  - Then immediately start divu 9/3 -> 3.
  - Repeat with rst_n=0 mid-operation -> all outputs 0.
- Busy handling and back-to-back:
  - Pulse start_i with different operands while busy -> ignored, first result unaffected.
  - Start on the edge after done_o -> accepted, second result correct.
  - Random 10k-operand sweep vs reference model including the edge operands 0, 1, -1 and 0x80000000.
